ucsbece154a_memarb: RTL
=======================

Name: ucsbece154a_memarb

Overview:
Arbiter and sequencer for the single unified instruction/data memory of the multicycle core. It shares the memory between two requesters: port 0 is the core's multicycle memory interface, and port 1 is a loader/debug DMA. Each access runs through a fixed-latency issue/wait/response sequence, with round-robin selection between the ports.

Parameters:
LATENCY, 2, cycles from mem_en_o high to mem_rdata_i valid; legal range 1..15
AW, 32, address width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
p0_req_i  in  1  port 0 request; held high with addr/we/wdata stable until p0_ack_o
p0_we_i  in  1  port 0 write enable (1 = write)
p0_addr_i  in  AW  port 0 byte address
p0_wdata_i  in  32  port 0 write data
p0_rdata_o  out  32  port 0 read data; valid when p0_ack_o is high, held afterwards
p0_ack_o  out  1  one-cycle completion pulse for port 0
p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_rdata_o, p1_ack_o  same as port 0, for port 1
p1_lock_i  in  1  port 1 bus-lock request (used only with MEMARB_LOCK_EN)
mem_en_o  out  1  memory access strobe, one cycle per transaction
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  AW  memory address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data, valid LATENCY cycles after mem_en_o
busy_o  out  1  high in every state except IDLE
grant_o  out  1  port currently owning the memory; meaningful only while busy_o is high

Behaviour:
- All outputs are registered. Reset (reset=0) acts immediately and asynchronously: state=IDLE; every output = 0; last_grant = 1; lock flag = 0; wait counter = 0.
- States and transitions:
  - IDLE: if any req is high, select a port, latch the selected addr/we/wdata into the mem_* output registers, set grant_o, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle. mem_en_o=1; mem_we_o equals the latched we. Load counter = LATENCY-1 and go to WAIT.
  - WAIT: lasts exactly LATENCY cycles. The counter decrements each cycle. When the counter is 0, capture mem_rdata_i and go to RESP.
  - RESP: exactly one cycle. ack_o=1 for the granted port only. On a read, that port's rdata_o is updated with the captured data. Go to IDLE. No new grant is made in RESP, so a stale req is never re-granted.
- Timing, with c0 = the cycle req is seen high in IDLE:
  - mem_en_o is high in c1.
  - ack_o is high in c(LATENCY+2).
  - Back-to-back requests from the same port are spaced LATENCY+3 cycles apart.
- mem_en_o and mem_we_o are 0 outside ISSUE. mem_addr_o and mem_wdata_o hold their latched values from ISSUE until the next grant.
- Writes follow the identical sequence, including the WAIT phase. A write never changes rdata_o.
- Selection in IDLE:
  - Only one port requesting: that port is granted.
  - Both ports requesting: grant the port that is not last_grant.
  - last_grant updates on every grant. Its reset value of 1 makes port 0 win the first tie.
- A request arriving on either port while busy_o=1 waits; it is never dropped.
- A req deasserted mid-transaction is a protocol violation. The transaction still completes and ack_o still pulses.
- Reset asserted mid-transaction: the in-flight access is abandoned and no ack is produced after reset is released. A write already strobed to memory is not undone.

Optional Feature:
MEMARB_LOCK_EN
- Defined:
  - If p1_lock_i=1 in the RESP cycle of a port-1 transaction, the lock flag is set.
  - While the lock flag is set, IDLE grants only port 1 and port 0 waits. The round-robin rule is suspended.
  - The lock flag clears in IDLE when p1_lock_i=0. Normal arbitration then resumes in that same cycle.
- Undefined: p1_lock_i is ignored, there is no lock flag, and arbitration is pure round-robin.

Test Plan:
1. LATENCY=2; p0 reads 0x10 and memory returns 0xDEADBEEF -> mem_en_o high one cycle at c1 with mem_addr_o=0x10 and mem_we_o=0; p0_ack_o pulses at c4; p0_rdata_o=0xDEADBEEF; p1_ack_o stays 0.
2. p0 and p1 both request continuously from reset -> grants alternate p0, p1, p0, p1; each ack is LATENCY+3 cycles after the previous one.
3. p1 writes 0x20 with data 0x12345678 -> a single cycle with mem_en_o=1, mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678; p1_ack_o pulses at c4; p1_rdata_o unchanged.
4. reset driven low during WAIT of a p0 read -> all outputs 0 immediately; after release, no ack for the abandoned read; a new p0 request completes normally.
5. MEMARB_LOCK_EN defined; p0 and p1 both requesting; p1_lock_i=1 for the first three p1 transactions -> after the first p1 grant, the next three grants go to p1; once p1_lock_i=0, the next grant goes to p0.
6. LATENCY=1; p0 reads 0x04 -> mem_en_o at c1, p0_ack_o at c3; busy_o is high in c1..c3 and low in c4.

Source files
------------

// File: rtl/ucsbece154a_memarb_if.sv
// ----------------------------------------------------------------------------
// ucsbece154a_memarb_if
//
// Signal bundle between the unified-memory arbiter and its surroundings:
// two requester ports, the port-1 bus-lock line and the shared memory bus.
//
//   p0_* / p1_*   requester ports (req/we/addr/wdata in, rdata/ack out)
//   p1_lock_i     port 1 bus-lock request (only meaningful with MEMARB_LOCK_EN)
//   mem_*         shared memory bus (en/we/addr/wdata out, rdata in)
//   busy_o        arbiter not idle
//   grant_o       port owning the memory while busy_o is high
//
// Modports:
//   slave  - the arbiter side (ucsbece154a_memarb)
//   master - the requesters plus memory model side
// ----------------------------------------------------------------------------
interface ucsbece154a_memarb_if #(
    parameter int AW = 32
) ();

    // Port 0: core multicycle memory interface
    logic          p0_req_i;
    logic          p0_we_i;
    logic [AW-1:0] p0_addr_i;
    logic [31:0]   p0_wdata_i;
    logic [31:0]   p0_rdata_o;
    logic          p0_ack_o;

    // Port 1: loader / debug DMA
    logic          p1_req_i;
    logic          p1_we_i;
    logic [AW-1:0] p1_addr_i;
    logic [31:0]   p1_wdata_i;
    logic [31:0]   p1_rdata_o;
    logic          p1_ack_o;
    logic          p1_lock_i;

    // Shared memory bus
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    // Status
    logic          busy_o;
    logic          grant_o;

    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p0_rdata_o, p0_ack_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        output p1_rdata_o, p1_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output busy_o, grant_o
    );

    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p0_rdata_o, p0_ack_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        input  p1_rdata_o, p1_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  busy_o, grant_o
    );

endinterface

// File: rtl/ucsbece154a_memarb.sv
// ----------------------------------------------------------------------------
// ucsbece154a_memarb
//
// Arbiter and sequencer for the unified instruction/data memory of the
// multicycle core. Two requesters (port 0 = core, port 1 = loader/debug DMA)
// share one fixed-latency memory. Every access runs IDLE -> ISSUE -> WAIT ->
// RESP; ties in IDLE are broken round-robin.
//
// Parameters:
//   LATENCY  cycles from mem_en_o high to mem_rdata_i valid (1..15)
//   AW       address width
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous, active-low reset
//   bus      ucsbece154a_memarb_if.slave (requester ports, memory bus, status)
//
// Optional feature macro: MEMARB_LOCK_EN
//   When defined, port 1 may hold the memory across transactions by keeping
//   p1_lock_i high; otherwise p1_lock_i is ignored.
//
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ucsbece154a_memarb #(
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    ucsbece154a_memarb_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // WAIT spans LATENCY cycles, counting LATENCY-1 down to 0.
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;

    logic          sel_vld;
    logic          sel_port;

`ifdef MEMARB_LOCK_EN
    logic          lock_q, lock_d;
`else
    logic          unused_lock;
    assign unused_lock = bus.p1_lock_i;
`endif

    // ------------------------------------------------------------------
    // Port selection used in IDLE
    // ------------------------------------------------------------------
    always_comb begin
        sel_vld = bus.p0_req_i | bus.p1_req_i;
        if (bus.p0_req_i && bus.p1_req_i) begin
            sel_port = ~last_grant_q;
        end else begin
            sel_port = bus.p1_req_i;
        end
`ifdef MEMARB_LOCK_EN
        // A held lock restricts the grant to port 1. Dropping p1_lock_i in
        // IDLE releases it and normal arbitration applies this same cycle.
        if (lock_q && bus.p1_lock_i) begin
            sel_vld  = bus.p1_req_i;
            sel_port = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef MEMARB_LOCK_EN
        lock_d       = lock_q;
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef MEMARB_LOCK_EN
                lock_d = lock_q & bus.p1_lock_i;
`endif
                if (sel_vld) begin
                    grant_d      = sel_port;
                    last_grant_d = sel_port;
                    if (sel_port) begin
                        we_d        = bus.p1_we_i;
                        mem_addr_d  = bus.p1_addr_i;
                        mem_wdata_d = bus.p1_wdata_i;
                    end else begin
                        we_d        = bus.p0_we_i;
                        mem_addr_d  = bus.p0_addr_i;
                        mem_wdata_d = bus.p0_wdata_i;
                    end
                    // Strobe is registered, so it is raised on entry to ISSUE.
                    mem_en_d = 1'b1;
                    mem_we_d = sel_port ? bus.p1_we_i : bus.p0_we_i;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Read data is valid now; load it straight into the
                    // granted port's rdata register alongside the ack.
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = bus.mem_rdata_i;
                        end else begin
                            rdata0_d = bus.mem_rdata_i;
                        end
                    end
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP: begin
`ifdef MEMARB_LOCK_EN
                if (grant_q && bus.p1_lock_i) begin
                    lock_d = 1'b1;
                end
`endif
                // No grant here: the finishing requester's req is still high
                // and must not be taken as a fresh request.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef MEMARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign bus.p0_rdata_o  = rdata0_q;
    assign bus.p0_ack_o    = ack0_q;
    assign bus.p1_rdata_o  = rdata1_q;
    assign bus.p1_ack_o    = ack1_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.busy_o      = busy_q;
    assign bus.grant_o     = grant_q;

endmodule
